// File: rtl/div_tick_sched_pkg.sv
// Shared types and default parameters for the div_tick_sched timer scheduler.
package div_tick_sched_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned CW_DEF = 16;
  localparam int unsigned TW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/div_tick_sched_arb.sv
// rr_arbiter: N-way round-robin pick. The scan starts at ptr_i and wraps
// modulo N; outputs are combinational (one-hot grant, index, valid).
module rr_arbiter
  import div_tick_sched_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c_o,
  output logic [IW-1:0] idx_c_o,
  output logic          valid_c_o
);

  int unsigned pos;

  // First requester at or after ptr_i in circular order wins.
  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    pos       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_i) + k) % N;
      if (!valid_c_o && req_i[IW'(pos)]) begin
        gnt_c_o[IW'(pos)] = 1'b1;
        idx_c_o           = IW'(pos);
        valid_c_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_tick_sched.sv
// div_tick_sched: one countdown timer shared by N requesters. The timer
// counts rising edges of a requester-chosen clkdiv bit and pulses done to
// the owner when its count is exhausted.
// Build option: DIV_TICK_SCHED_ABORT_EN -- owner dropping req during RUN
// aborts the job (no done pulse). Undefined: the job always completes.
module div_tick_sched
  import div_tick_sched_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     clkdiv,
  input  logic [N-1:0]    req,
  input  logic [N*TW-1:0] tap,
  input  logic [N*CW-1:0] cnt,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            tick
);

  localparam int unsigned IW = $clog2(N);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          busy_q, busy_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [TW-1:0] sel_tap_q, sel_tap_d;
  logic          prev_bit_q, prev_bit_d;

  logic [N-1:0]  arb_gnt_c;
  logic [IW-1:0] arb_idx_c;
  logic          arb_valid_c;
  logic [TW-1:0] own_tap_c;
  logic [CW-1:0] own_cnt_c;
  logic          live_bit_c;
  logic [IW-1:0] next_ptr_c;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_c_o   (arb_gnt_c),
    .idx_c_o   (arb_idx_c),
    .valid_c_o (arb_valid_c)
  );

  // Owner's live configuration, only sampled in LOAD.
  assign own_tap_c  = tap[owner_q*TW +: TW];
  assign own_cnt_c  = cnt[owner_q*CW +: CW];
  assign live_bit_c = clkdiv[sel_tap_q];
  assign next_ptr_c = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      remaining_q <= '0;
      sel_tap_q   <= '0;
      prev_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      remaining_q <= remaining_d;
      sel_tap_q   <= sel_tap_d;
      prev_bit_q  <= prev_bit_d;
    end
  end

  // Next-state and next-output logic for the IDLE/LOAD/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    tick_d      = 1'b0;
    remaining_d = remaining_q;
    sel_tap_d   = sel_tap_q;
    prev_bit_d  = prev_bit_q;

    case (state_q)
      S_IDLE: begin
        // Grant of the previous owner drops here unless a new one is picked.
        gnt_d = arb_gnt_c;
        if (arb_valid_c) begin
          owner_d = arb_idx_c;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Seeding prev_bit with the current level hides an edge in this cycle.
        sel_tap_d   = own_tap_c;
        remaining_d = own_cnt_c;
        prev_bit_d  = clkdiv[own_tap_c];
        state_d     = (own_cnt_c == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        prev_bit_d = live_bit_c;
        if (live_bit_c && !prev_bit_q) begin
          tick_d = 1'b1;
          if (remaining_q == CW'(1)) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - CW'(1);
          end
        end
`ifdef DIV_TICK_SCHED_ABORT_EN
        if (!req[owner_q]) begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          tick_d      = 1'b0;
          remaining_d = remaining_q;
          rr_ptr_d    = next_ptr_c;
        end
`endif
      end
      S_DONE: begin
        done_d   = gnt_q;
        rr_ptr_d = next_ptr_c;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign tick = tick_q;

endmodule
